// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_burst_reader_if : command, FIFO-read and output-stream signals
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface fifo_burst_reader_if #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;
  logic             fifo_empty;
  logic [SIZE-1:0]  fifo_data;
  logic             fifo_read_update;
  logic             out_valid;
  logic             out_ready;
  logic [SIZE-1:0]  out_data;
  logic             out_last;

  modport master (
    input  start, count, fifo_empty, fifo_data, out_ready,
    output busy, done, fifo_read_update, out_valid, out_data, out_last
  );

  modport slave (
    output start, count, fifo_empty, fifo_data, out_ready,
    input  busy, done, fifo_read_update, out_valid, out_data, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_burst_reader : pops a commanded burst from a FWFT FIFO into a
//                     valid/ready stream through a 2-entry skid buffer
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 8
) (
  input  wire logic           clk,
  input  wire logic           reset,
  fifo_burst_reader_if.master bus
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_remaining;
  logic [CNT_W-1:0] r_sent;
  logic [1:0]       r_occ;
  logic [SIZE-1:0]  r_skid0;
  logic [SIZE-1:0]  r_skid1;
  logic             w_pop;
  logic             w_hs;
  logic             w_busy;
  logic             w_done;

  // Pop decision uses only registered state and fifo_empty, never out_ready
  assign w_pop = (r_state == S_STREAM) && (r_remaining != '0) &&
                 !bus.fifo_empty && !r_occ[1];
  assign w_hs  = (r_occ != 2'd0) && bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_state_nxt = (bus.count == '0) ? S_DONE : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_pop && (r_remaining == c_one)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_sent == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_sent      <= '0;
      r_occ       <= 2'd0;
      r_skid0     <= '0;
      r_skid1     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == S_IDLE) && bus.start) begin
        r_remaining <= bus.count;
        r_sent      <= bus.count;
      end else begin
        if (w_pop) r_remaining <= r_remaining - c_one;
        if (w_hs)  r_sent      <= r_sent - c_one;
      end

      // r_skid0 is always the oldest entry
      case ({w_pop, w_hs})
        2'b10: begin
          if (r_occ == 2'd0) r_skid0 <= bus.fifo_data;
          else               r_skid1 <= bus.fifo_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_skid0 <= r_skid1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_skid0 <= bus.fifo_data;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= bus.fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy             = w_busy;
  assign bus.done             = w_done;
  assign bus.fifo_read_update = w_pop;
  assign bus.out_valid        = (r_occ != 2'd0);
  assign bus.out_data         = r_skid0;
  assign bus.out_last         = (r_occ != 2'd0) && (r_sent == c_one);

endmodule
`default_nettype wire
